// File: rtl/scsp_midi_tx.sv
// scsp_midi_tx -- SCSP MIDI output path (drain side of CR3 MOBUF).
// Bytes written through MOBUF are queued in a small FIFO and sent as
// 31250-baud 8N1 frames on MIDI_TXD, LSB first. OE/OF feed CR2.
// Optional build macro: SCSP_MIDI_TX_IRQ_EN adds the MOIRQ output, a one-clock
// pulse raised when a pop empties the FIFO.
module scsp_midi_tx #(
  parameter int BAUD_DIV   = 722,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       CE,
  input  logic       MOBUF_WR,
  input  logic [7:0] MOBUF_DI,
  input  logic       OF_CLR,
  output logic       OE,
  output logic       OF,
  output logic       BUSY,
  output logic       MIDI_TXD
`ifdef SCSP_MIDI_TX_IRQ_EN
  ,
  output logic       MOIRQ
`endif
);

  localparam int              AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]     DEPTH_C  = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0]     CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0]   PTR_ONE  = AW'(1);
  localparam logic [11:0]     DIV_LAST = 12'(BAUD_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Transmitter state
  state_t      state_reg, state_next;
  logic [11:0] div_reg, div_next;
  logic [2:0]  bit_reg, bit_next;
  logic [7:0]  sr_reg, sr_next;
  logic        txd_reg, txd_next;
  logic        pop;

  // FIFO state
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg, count_next;
  logic          oe_reg, of_reg;
  logic          push, drop;
  logic [7:0]    head;
  logic          fifo_empty, fifo_full, last_tick;

  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == DEPTH_C);
  assign head       = mem[rd_ptr_reg];
  assign last_tick  = (div_reg == DIV_LAST);

  // A write into a full FIFO still lands when the transmitter frees a slot
  // on the same edge; otherwise it is dropped and flagged as overflow.
  assign push = MOBUF_WR && (!fifo_full || pop);
  assign drop = MOBUF_WR && fifo_full && !pop;

  // Occupancy update: simultaneous push and pop leave the count unchanged.
  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_ONE;
      2'b01:   count_next = count_reg - CNT_ONE;
      default: count_next = count_reg;
    endcase
  end

  // FIFO storage; no reset so it maps onto plain distributed memory.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr_reg] <= MOBUF_DI;
    end
  end

  // FIFO pointers, count and the CR2 flags.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      oe_reg     <= 1'b1;
      of_reg     <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      count_reg <= count_next;
      oe_reg    <= (count_next == '0);
      // Set has priority over clear so a coincident overflow is never lost.
      if (drop)        of_reg <= 1'b1;
      else if (OF_CLR) of_reg <= 1'b0;
    end
  end

  // Transmitter next-state logic; nothing moves unless CE is high.
  always_comb begin
    state_next = state_reg;
    div_next   = div_reg;
    bit_next   = bit_reg;
    sr_next    = sr_reg;
    txd_next   = txd_reg;
    pop        = 1'b0;
    if (CE) begin
      div_next = last_tick ? 12'd0 : div_reg + 12'd1;
      case (state_reg)
        IDLE: begin
          div_next = 12'd0;
          txd_next = 1'b1;
          if (!fifo_empty) begin
            pop        = 1'b1;
            sr_next    = head;
            txd_next   = 1'b0;
            state_next = START;
          end
        end
        START: begin
          if (last_tick) begin
            txd_next   = sr_reg[0];
            bit_next   = 3'd0;
            state_next = DATA;
          end
        end
        DATA: begin
          if (last_tick) begin
            if (bit_reg == 3'd7) begin
              txd_next   = 1'b1;
              state_next = STOP;
            end else begin
              sr_next  = {1'b0, sr_reg[7:1]};
              txd_next = sr_reg[1];
              bit_next = bit_reg + 3'd1;
            end
          end
        end
        STOP: begin
          if (last_tick) begin
            if (!fifo_empty) begin
              // Back-to-back frame: start bit begins on the stop bit's last tick.
              pop        = 1'b1;
              sr_next    = head;
              txd_next   = 1'b0;
              div_next   = 12'd0;
              state_next = START;
            end else begin
              txd_next   = 1'b1;
              state_next = IDLE;
            end
          end
        end
        default: begin
          txd_next   = 1'b1;
          div_next   = 12'd0;
          state_next = IDLE;
        end
      endcase
    end
  end

  // Transmitter registers; reset forces the line idle immediately.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg <= IDLE;
      div_reg   <= 12'd0;
      bit_reg   <= 3'd0;
      sr_reg    <= 8'd0;
      txd_reg   <= 1'b1;
    end else begin
      state_reg <= state_next;
      div_reg   <= div_next;
      bit_reg   <= bit_next;
      sr_reg    <= sr_next;
      txd_reg   <= txd_next;
    end
  end

`ifdef SCSP_MIDI_TX_IRQ_EN
  logic moirq_reg;

  // One-clock pulse when a pop drains the last queued byte.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      moirq_reg <= 1'b0;
    end else begin
      moirq_reg <= pop && (count_next == '0);
    end
  end

  assign MOIRQ = moirq_reg;
`endif

  assign OE       = oe_reg;
  assign OF       = of_reg;
  assign BUSY     = (state_reg != IDLE);
  assign MIDI_TXD = txd_reg;

endmodule

// File: tb/tb_scsp_midi_tx.sv
// tb_scsp_midi_tx -- directed bench for scsp_midi_tx (BAUD_DIV=4, FIFO_DEPTH=4).
// Single-frame cases come from a vector table; back-to-back, overflow and
// mid-frame reset are hand-written sequences.
module tb_scsp_midi_tx;

  localparam int BD = 4;
  localparam int FD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ce = 1'b1;
  logic       wr = 1'b0;
  logic [7:0] di = 8'h00;
  logic       of_clr = 1'b0;
  logic       oe, of_flag, busy, txd;
`ifdef SCSP_MIDI_TX_IRQ_EN
  logic       moirq;
`endif

  int irq_cnt = 0;

  always #5 clk = ~clk;

  scsp_midi_tx #(
    .BAUD_DIV  (BD),
    .FIFO_DEPTH(FD)
  ) dut (
    .CLK      (clk),
    .RST_N    (rst_n),
    .CE       (ce),
    .MOBUF_WR (wr),
    .MOBUF_DI (di),
    .OF_CLR   (of_clr),
    .OE       (oe),
    .OF       (of_flag),
    .BUSY     (busy),
    .MIDI_TXD (txd)
`ifdef SCSP_MIDI_TX_IRQ_EN
    ,
    .MOIRQ    (moirq)
`endif
  );

  int         n_pass = 0;
  int         n_total = 0;
  bit         ce_gate = 1'b0;
  logic [7:0] wq[$];

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;   // bit 0 = start bit ... bit 9 = stop bit
    int         m;       // CLK cycles per CE tick
    string      name;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // One clock: apply the next queued write (if any), step past the edge,
  // then toggle CE when gating is enabled.
  task automatic tick();
    if (wq.size() > 0) begin
      wr = 1'b1;
      di = wq.pop_front();
    end else begin
      wr = 1'b0;
    end
    @(posedge clk);
    #1;
`ifdef SCSP_MIDI_TX_IRQ_EN
    if (moirq === 1'b1) irq_cnt++;
`endif
    if (ce_gate) ce = ~ce;
  endtask

  task automatic wait_busy(output int n);
    n = 0;
    while (busy !== 1'b1 && n < 12) begin
      tick();
      n++;
    end
  endtask

  // Checks every CLK cycle of all ten bits; one comparison per bit.
  task automatic check_frame(input string name, input logic [9:0] f, input int m);
    for (int b = 0; b < 10; b++) begin
      int bad;
      bad = 0;
      for (int c = 0; c < BD * m; c++) begin
        if (txd !== f[b] || busy !== 1'b1) bad++;
        tick();
      end
      chk($sformatf("%s bit%0d bad cycles", name, b), bad, 0);
    end
    $display("frame %s: bits 0x%03h checked", name, f);
  endtask

  initial begin
    vec_t vt[4];
    int   n;
    int   bad;

    vt[0] = '{8'h55, 10'h2AA, 1, "single 0x55"};
    vt[1] = '{8'hA3, 10'h346, 2, "ce-gated 0xA3"};
    vt[2] = '{8'h00, 10'h200, 1, "single 0x00"};
    vt[3] = '{8'hFF, 10'h3FE, 1, "single 0xFF"};

    // Reset and idle
    repeat (3) tick();
    chk("reset txd", txd, 1);
    chk("reset oe", oe, 1);
    chk("reset of", of_flag, 0);
    chk("reset busy", busy, 0);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (txd !== 1'b1 || oe !== 1'b1 || of_flag !== 1'b0 || busy !== 1'b0) bad++;
    end
    chk("idle 100 cycles bad", bad, 0);
    $display("reset/idle sequence checked");

    // Table-driven single frames
    for (int i = 0; i < 4; i++) begin
      ce_gate = (vt[i].m == 2);
      ce = 1'b1;
      irq_cnt = 0;
      wq.push_back(vt[i].data);
      wait_busy(n);
      if (vt[i].m == 1) chk({vt[i].name, " start latency"}, n, 2);
      else              chk({vt[i].name, " started"}, busy, 1);
      chk({vt[i].name, " oe after pop"}, oe, 1);
      check_frame(vt[i].name, vt[i].frame, vt[i].m);
      chk({vt[i].name, " busy after frame"}, busy, 0);
      chk({vt[i].name, " txd after frame"}, txd, 1);
`ifdef SCSP_MIDI_TX_IRQ_EN
      chk({vt[i].name, " moirq pulses"}, irq_cnt, 1);
`endif
      ce_gate = 1'b0;
      ce = 1'b1;
      repeat (3) tick();
    end

    // Back-to-back frames
    wq.push_back(8'h01);
    wq.push_back(8'h80);
    wq.push_back(8'hFF);
    wait_busy(n);
    chk("b2b start latency", n, 2);
    chk("b2b oe while queued", oe, 0);
    check_frame("b2b 0x01", 10'h202, 1);
    chk("b2b oe after 2nd pop", oe, 0);
    check_frame("b2b 0x80", 10'h300, 1);
    chk("b2b oe after 3rd pop", oe, 1);
    check_frame("b2b 0xFF", 10'h3FE, 1);
    chk("b2b busy end", busy, 0);
    chk("b2b no overflow", of_flag, 0);

    // Overflow: one byte in flight, four queued, sixth dropped
    repeat (3) tick();
    wq.push_back(8'h11);
    wq.push_back(8'h22);
    wq.push_back(8'h33);
    wq.push_back(8'h44);
    wq.push_back(8'h55);
    wq.push_back(8'h66);
    wait_busy(n);
    check_frame("ovf 0x11", 10'h222, 1);
    chk("ovf of set", of_flag, 1);
    check_frame("ovf 0x22", 10'h244, 1);
    check_frame("ovf 0x33", 10'h266, 1);
    check_frame("ovf 0x44", 10'h288, 1);
    check_frame("ovf 0x55", 10'h2AA, 1);
    chk("ovf of sticky", of_flag, 1);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy !== 1'b0 || txd !== 1'b1) bad++;
      tick();
    end
    chk("ovf dropped byte not sent", bad, 0);
    chk("ovf oe empty", oe, 1);
    of_clr = 1'b1;
    tick();
    of_clr = 1'b0;
    chk("ovf of cleared", of_flag, 0);

    // Reset in the middle of data bit 3 of 0x0F
    repeat (2) tick();
    wq.push_back(8'h0F);
    wait_busy(n);
    repeat (17) tick();
    chk("midframe busy before reset", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("midframe reset txd", txd, 1);
    chk("midframe reset oe", oe, 1);
    chk("midframe reset busy", busy, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    wq.push_back(8'h42);
    wait_busy(n);
    chk("post-reset start latency", n, 2);
    check_frame("post-reset 0x42", 10'h284, 1);
    chk("post-reset busy end", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
